display_datapath: RTL and testbench
===================================

# display_datapath

Pixel datapath directly downstream of the display control FSM. It consumes the FSM's load/write strobes and its grid, box, song and pixel counters. It holds the scrolling 8-row × 4-lane note window and produces registered x/y/colour/plot writes for the 160×120, 3-bit-colour VGA adapter. All geometry is computed here; the FSM only sequences.

## Interface
Parameters:
- BOX_W, 16: note box width in pixels (≤16)
- BOX_H, 12: note box height in pixels (≤16)
- LANE_X0, 32: x of lane 0 box left edge
- LANE_PITCH, 24: x distance between lanes
- ROW_Y0, 8: y of row 0 box top edge
- ROW_PITCH, 14: y distance between rows
- BG_COLOUR, 3'b000: background / empty-box colour

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- loadDefault  in  1  latch clear-screen pixel address from gridCounter
- writeDefault  in  1  emit clear-screen pixel
- loadStartAddress  in  1  latch box base address and note bit for (boxCounter, songCounter)
- loadX  in  1  latch x = base x + pixel x offset
- loadY  in  1  latch y = base y + pixel y offset
- writeToScreen  in  1  emit box pixel
- shiftSong  in  1  advance note window one row
- noteIn  in  4  new row entering row 0 on shiftSong, bit i = lane i
- gridCounter  in  16  clear-screen index: [7:0] = x, [14:8] = y, [15] ignored
- boxCounter  in  2  lane 0..3
- songCounter  in  3  row 0..7 (row 7 = strike row, bottom)
- pixelCount  in  16  box pixel index: [3:0] = x offset, [7:4] = y offset, upper bits ignored
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- plot  out  1  write enable to VGA adapter, one cycle per pixel
- strikeRow  out  4  current row 7 contents

## Operation
- Note window: 32-bit register, row r lane l. On shiftSong: row r ← row r−1 for r=7..1, row 0 ← noteIn; old row 7 is discarded. strikeRow is row 7 (register output).
- loadStartAddress: baseX ← LANE_X0 + boxCounter·LANE_PITCH (8-bit); baseY ← ROW_Y0 + songCounter·ROW_PITCH (7-bit); boxColour ← lane colour if note(songCounter, boxCounter) else BG_COLOUR. Lane colours: 0 = 3'b100, 1 = 3'b010, 2 = 3'b001, 3 = 3'b110. The note bit is sampled at this edge only.
- loadX: x ← baseX + pixelCount[3:0]; xIn ← (pixelCount[3:0] < BOX_W). loadY: y ← baseY + pixelCount[7:4]; yIn ← (pixelCount[7:4] < BOX_H). Each loads independently; both may be high together.
- writeToScreen: next cycle plot = xIn & yIn, colour ← boxColour.
- loadDefault: x ← gridCounter[7:0], y ← gridCounter[14:8], defValid ← (x<160 and y<120). writeDefault: next cycle plot = defValid, colour ← BG_COLOUR.
- Priority when asserted together: loadDefault over loadStartAddress/loadX/loadY; writeDefault over writeToScreen. shiftSong is independent and may coincide with any strobe.
- Additions truncate to output width. Defaults keep the result in range; no wrap checking.

## Timing
- Reset values: x=0, y=0, colour=0, plot=0, strikeRow=0, window=0, baseX=baseY=0, boxColour=0, xIn=yIn=defValid=0.
- Box pixel: loadStartAddress @n, loadX/loadY @n+1, writeToScreen @n+2 → plot=1 with x, y, colour valid during cycle n+3.
- loadStartAddress, loadX/loadY and writeToScreen may share a cycle. Each uses register values from before that edge.
- Clear pixel: loadDefault @n, writeDefault @n+1 → plot during n+2.
- plot is high for exactly one cycle per accepted write strobe and low otherwise. Back-to-back write strobes give back-to-back plots.
- shiftSong after loadStartAddress does not change that box's colour. strikeRow updates the cycle after shiftSong.
- Reset asserted mid-draw: plot drops to 0 asynchronously. The window is lost; no pending plot survives deassertion.

## Test plan
- Reset, shift noteIn=4'b0100 eight times → strikeRow=4'b0100 after 8th shift; after 7th shift strikeRow=0.
- With row 7 lane 2 set: boxCounter=2, songCounter=7, pixelCount=16'h0035, strobe sequence → plot one cycle, x=85, y=109, colour=3'b001.
- Same box, lane 2 empty → colour=BG_COLOUR. pixelCount=16'h00C0 (y offset 12 ≥ BOX_H) → plot stays 0.
- shiftSong in the cycle after loadStartAddress → drawn colour matches pre-shift note.
- gridCounter=16'h0A9F (x=159, y=10) → plot, x=159, y=10, colour=0. gridCounter=16'h00A0 (x=160) → no plot.
- Drop reset during the writeToScreen cycle → plot=0, x=y=colour=0. Release reset, then writeToScreen alone → plot=0 (xIn/yIn cleared).

Source files
------------

// File: rtl/display_datapath.sv
// Pixel datapath for the note-lane display: holds the scrolling 8x4 note
// window, computes box and clear-screen pixel addresses, and produces
// registered x/y/colour/plot writes for a 160x120 3-bit VGA adapter.
module display_datapath #(
  parameter int         BOX_W      = 16,
  parameter int         BOX_H      = 12,
  parameter int         LANE_X0    = 32,
  parameter int         LANE_PITCH = 24,
  parameter int         ROW_Y0     = 8,
  parameter int         ROW_PITCH  = 14,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        loadDefault,
  input  logic        writeDefault,
  input  logic        loadStartAddress,
  input  logic        loadX,
  input  logic        loadY,
  input  logic        writeToScreen,
  input  logic        shiftSong,
  input  logic [3:0]  noteIn,
  input  logic [15:0] gridCounter,
  input  logic [1:0]  boxCounter,
  input  logic [2:0]  songCounter,
  input  logic [15:0] pixelCount,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic [3:0]  strikeRow
);

  // Window bit (4*row + lane); row 0 is the newest, row 7 the strike row.
  logic [31:0] window_q, window_d;
  logic [7:0]  base_x_q, base_x_d;
  logic [6:0]  base_y_q, base_y_d;
  logic [2:0]  box_colour_q, box_colour_d;
  logic        x_in_q, x_in_d;
  logic        y_in_q, y_in_d;
  logic        def_valid_q, def_valid_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  colour_q, colour_d;
  logic        plot_q, plot_d;

  logic [2:0]  lane_colour;
  logic        note_bit;
  logic        unused_bits;

  assign unused_bits = ^{pixelCount[15:8], gridCounter[15]};
  assign note_bit    = window_q[{songCounter, boxCounter}];

  // Fixed per-lane colour of a note that is present.
  always_comb begin
    lane_colour = 3'b100;
    case (boxCounter)
      2'd0: lane_colour = 3'b100;
      2'd1: lane_colour = 3'b010;
      2'd2: lane_colour = 3'b001;
      2'd3: lane_colour = 3'b110;
      default: lane_colour = 3'b100;
    endcase
  end

  // Next-state for window, box address latches and pixel output registers.
  always_comb begin
    window_d     = window_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    box_colour_d = box_colour_q;
    x_in_d       = x_in_q;
    y_in_d       = y_in_q;
    def_valid_d  = def_valid_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;

    if (shiftSong) begin
      window_d = {window_q[27:0], noteIn};
    end

    if (loadDefault) begin
      x_d         = gridCounter[7:0];
      y_d         = gridCounter[14:8];
      def_valid_d = (gridCounter[7:0] < 8'd160) && (gridCounter[14:8] < 7'd120);
    end else begin
      if (loadStartAddress) begin
        base_x_d     = 8'(LANE_X0 + int'(boxCounter) * LANE_PITCH);
        base_y_d     = 7'(ROW_Y0 + int'(songCounter) * ROW_PITCH);
        box_colour_d = note_bit ? lane_colour : BG_COLOUR;
      end
      if (loadX) begin
        x_d    = base_x_q + {4'b0000, pixelCount[3:0]};
        x_in_d = ({1'b0, pixelCount[3:0]} < 5'(BOX_W));
      end
      if (loadY) begin
        y_d    = base_y_q + {3'b000, pixelCount[7:4]};
        y_in_d = ({1'b0, pixelCount[7:4]} < 5'(BOX_H));
      end
    end

    if (writeDefault) begin
      plot_d   = def_valid_q;
      colour_d = BG_COLOUR;
    end else if (writeToScreen) begin
      plot_d   = x_in_q & y_in_q;
      colour_d = box_colour_q;
    end
  end

  // All state registers, cleared immediately when reset goes low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      window_q     <= '0;
      base_x_q     <= '0;
      base_y_q     <= '0;
      box_colour_q <= '0;
      x_in_q       <= 1'b0;
      y_in_q       <= 1'b0;
      def_valid_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
    end else begin
      window_q     <= window_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      box_colour_q <= box_colour_d;
      x_in_q       <= x_in_d;
      y_in_q       <= y_in_d;
      def_valid_q  <= def_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign strikeRow = window_q[31:28];

endmodule

// File: tb/tb_display_datapath.sv
// Self-checking bench for display_datapath: directed vector table of box and
// clear-screen draws plus hand-written window, priority and reset sequences.
module tb_display_datapath;

  logic        clock;
  logic        reset;
  logic        loadDefault;
  logic        writeDefault;
  logic        loadStartAddress;
  logic        loadX;
  logic        loadY;
  logic        writeToScreen;
  logic        shiftSong;
  logic [3:0]  noteIn;
  logic [15:0] gridCounter;
  logic [1:0]  boxCounter;
  logic [2:0]  songCounter;
  logic [15:0] pixelCount;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic [3:0]  strikeRow;

  int checks;
  int failures;

  typedef struct {
    logic        isClear;
    logic [1:0]  box;
    logic [2:0]  song;
    logic [15:0] data;
    logic        expPlot;
    logic        chkPos;
    logic [7:0]  expX;
    logic [6:0]  expY;
    logic [2:0]  expColour;
  } vec_t;

  vec_t vecs[10];

  display_datapath dut (
    .clock(clock),
    .reset(reset),
    .loadDefault(loadDefault),
    .writeDefault(writeDefault),
    .loadStartAddress(loadStartAddress),
    .loadX(loadX),
    .loadY(loadY),
    .writeToScreen(writeToScreen),
    .shiftSong(shiftSong),
    .noteIn(noteIn),
    .gridCounter(gridCounter),
    .boxCounter(boxCounter),
    .songCounter(songCounter),
    .pixelCount(pixelCount),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .strikeRow(strikeRow)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearStrobes();
    loadDefault      = 1'b0;
    writeDefault     = 1'b0;
    loadStartAddress = 1'b0;
    loadX            = 1'b0;
    loadY            = 1'b0;
    writeToScreen    = 1'b0;
    shiftSong        = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Run one full box or clear-screen strobe sequence; returns in the plot cycle.
  task automatic applyStimulus(input vec_t v);
    clearStrobes();
    if (v.isClear) begin
      gridCounter = v.data;
      loadDefault = 1'b1;
      step();
      clearStrobes();
      writeDefault = 1'b1;
      step();
      clearStrobes();
    end else begin
      boxCounter       = v.box;
      songCounter      = v.song;
      pixelCount       = v.data;
      loadStartAddress = 1'b1;
      step();
      clearStrobes();
      loadX = 1'b1;
      loadY = 1'b1;
      step();
      clearStrobes();
      writeToScreen = 1'b1;
      step();
      clearStrobes();
    end
  endtask

  task automatic shiftRow(input logic [3:0] note);
    noteIn    = note;
    shiftSong = 1'b1;
    step();
    shiftSong = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clearStrobes();
    noteIn      = 4'b0000;
    gridCounter = 16'h0000;
    boxCounter  = 2'd0;
    songCounter = 3'd0;
    pixelCount  = 16'h0000;

    // Window after eight shifts of 0100: lane 2 set in every row.
    vecs[0] = '{1'b0, 2'd2, 3'd7, 16'h0035, 1'b1, 1'b1, 8'd85,  7'd109, 3'b001};
    vecs[1] = '{1'b0, 2'd0, 3'd7, 16'h0035, 1'b1, 1'b1, 8'd37,  7'd109, 3'b000};
    vecs[2] = '{1'b0, 2'd2, 3'd0, 16'h0000, 1'b1, 1'b1, 8'd80,  7'd8,   3'b001};
    vecs[3] = '{1'b0, 2'd3, 3'd3, 16'h00BF, 1'b1, 1'b1, 8'd119, 7'd61,  3'b000};
    vecs[4] = '{1'b0, 2'd2, 3'd7, 16'h00C0, 1'b0, 1'b0, 8'd0,   7'd0,   3'b000};
    vecs[5] = '{1'b1, 2'd0, 3'd0, 16'h0A9F, 1'b1, 1'b1, 8'd159, 7'd10,  3'b000};
    vecs[6] = '{1'b1, 2'd0, 3'd0, 16'h00A0, 1'b0, 1'b0, 8'd0,   7'd0,   3'b000};
    vecs[7] = '{1'b1, 2'd0, 3'd0, 16'h7700, 1'b1, 1'b1, 8'd0,   7'd119, 3'b000};
    vecs[8] = '{1'b1, 2'd0, 3'd0, 16'h7800, 1'b0, 1'b0, 8'd0,   7'd0,   3'b000};
    vecs[9] = '{1'b1, 2'd0, 3'd0, 16'h8A05, 1'b1, 1'b1, 8'd5,   7'd10,  3'b000};

    // Reset state.
    reset = 1'b0;
    #12;
    checkOutput("reset_x", 32'(x), 32'd0);
    checkOutput("reset_y", 32'(y), 32'd0);
    checkOutput("reset_colour", 32'(colour), 32'd0);
    checkOutput("reset_plot", 32'(plot), 32'd0);
    checkOutput("reset_strike", 32'(strikeRow), 32'd0);
    reset = 1'b1;
    step();

    // Fill the window with lane 2 notes.
    for (int i = 0; i < 7; i++) shiftRow(4'b0100);
    checkOutput("strike_after7", 32'(strikeRow), 32'd0);
    shiftRow(4'b0100);
    checkOutput("strike_after8", 32'(strikeRow), 32'b0100);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_plot", i), 32'(plot), 32'(vecs[i].expPlot));
      if (vecs[i].chkPos) begin
        checkOutput($sformatf("vec%0d_x", i), 32'(x), 32'(vecs[i].expX));
        checkOutput($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].expY));
        checkOutput($sformatf("vec%0d_colour", i), 32'(colour), 32'(vecs[i].expColour));
      end
      step();
      checkOutput($sformatf("vec%0d_plot_drop", i), 32'(plot), 32'd0);
    end

    // Leave only row 7 with lane 2 set.
    for (int i = 0; i < 7; i++) shiftRow(4'b0000);
    checkOutput("strike_isolated", 32'(strikeRow), 32'b0100);

    // shiftSong right after loadStartAddress keeps the pre-shift note.
    boxCounter       = 2'd2;
    songCounter      = 3'd7;
    pixelCount       = 16'h0035;
    loadStartAddress = 1'b1;
    step();
    clearStrobes();
    loadX     = 1'b1;
    loadY     = 1'b1;
    shiftSong = 1'b1;
    noteIn    = 4'b0000;
    step();
    clearStrobes();
    checkOutput("strike_after_shift", 32'(strikeRow), 32'd0);
    writeToScreen = 1'b1;
    step();
    clearStrobes();
    checkOutput("shift_plot", 32'(plot), 32'd1);
    checkOutput("shift_colour", 32'(colour), 32'b001);

    // loadDefault beats box loads; writeDefault beats writeToScreen; back-to-back plots.
    gridCounter      = 16'h0A9F;
    boxCounter       = 2'd0;
    songCounter      = 3'd0;
    pixelCount       = 16'h0000;
    loadDefault      = 1'b1;
    loadStartAddress = 1'b1;
    loadX            = 1'b1;
    loadY            = 1'b1;
    step();
    clearStrobes();
    writeDefault  = 1'b1;
    writeToScreen = 1'b1;
    step();
    checkOutput("prio_plot", 32'(plot), 32'd1);
    checkOutput("prio_x", 32'(x), 32'd159);
    checkOutput("prio_y", 32'(y), 32'd10);
    checkOutput("prio_colour", 32'(colour), 32'd0);
    writeToScreen = 1'b0;
    step();
    checkOutput("b2b_plot", 32'(plot), 32'd1);
    clearStrobes();
    step();
    checkOutput("b2b_drop", 32'(plot), 32'd0);

    // Lane 2 row 7 is now empty, drawn in background colour.
    applyStimulus('{1'b0, 2'd2, 3'd7, 16'h0035, 1'b1, 1'b1, 8'd85, 7'd109, 3'b000});
    checkOutput("empty_plot", 32'(plot), 32'd1);
    checkOutput("empty_x", 32'(x), 32'd85);
    checkOutput("empty_y", 32'(y), 32'd109);
    checkOutput("empty_colour", 32'(colour), 32'(3'b000));

    // Reset while a plot is live, then writeToScreen alone afterwards.
    shiftRow(4'b0001);
    for (int i = 0; i < 7; i++) shiftRow(4'b0000);
    applyStimulus('{1'b0, 2'd0, 3'd7, 16'h0035, 1'b1, 1'b1, 8'd37, 7'd109, 3'b100});
    checkOutput("pre_reset_plot", 32'(plot), 32'd1);
    checkOutput("pre_reset_colour", 32'(colour), 32'(3'b100));
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_plot", 32'(plot), 32'd0);
    checkOutput("mid_reset_x", 32'(x), 32'd0);
    checkOutput("mid_reset_y", 32'(y), 32'd0);
    checkOutput("mid_reset_colour", 32'(colour), 32'd0);
    checkOutput("mid_reset_strike", 32'(strikeRow), 32'd0);
    #2;
    reset = 1'b1;
    step();
    writeToScreen = 1'b1;
    step();
    clearStrobes();
    checkOutput("post_reset_plot", 32'(plot), 32'd0);
    step();
    checkOutput("post_reset_plot2", 32'(plot), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
